// File: rtl/l2_wb_arbiter.sv
// l2_wb_arbiter: shares the single L2 request port between the icache miss path and the
// dcache miss/write-back path, with a one-entry write-back buffer.
//
// Dirty-line evictions are parked in the buffer and acknowledged at once. The buffer
// drains to L2 only when no read is waiting. Reads that hit the buffered line are served
// from the buffer, so L2 is never read while it still holds stale data for that line.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   iread/iaddress         icache line read request (held until iresp)
//   iresp/i_rdata          one-cycle read response to icache
//   dread/dwrite/daddress  dcache line read / write-back request (held until dresp)
//   wdata                  dcache write-back line
//   dresp/d_rdata          one-cycle response to dcache (read data or write accepted)
//   mem_read/mem_write     L2 strobes, never both high
//   mem_address/mem_wdata  L2 line address (offset bits zero) and write data
//   mem_rdata/mem_resp     L2 read data and completion pulse
module l2_wb_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256,
    parameter int unsigned OFF_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iread,
    input  logic [ADDR_W-1:0] iaddress,
    output logic              iresp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              dread,
    input  logic              dwrite,
    input  logic [ADDR_W-1:0] daddress,
    input  logic [LINE_W-1:0] wdata,
    output logic              dresp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    localparam logic [ADDR_W-1:0] OffMask = ADDR_W'((64'd1 << OFF_W) - 64'd1);

    typedef enum logic [2:0] {
        StIdle, StIrd, StDrd, StDrain, StFwdI, StFwdD, StWack, StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;          // line-aligned address of the granted read
    logic              buf_valid_q, buf_valid_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;  // always line-aligned
    logic [LINE_W-1:0] buf_data_q, buf_data_d;

    logic [ADDR_W-1:0] iaddr_line, daddr_line;
    logic              match_i, match_d;

    assign iaddr_line = iaddress & ~OffMask;
    assign daddr_line = daddress & ~OffMask;
    assign match_i    = buf_valid_q && (iaddr_line == buf_addr_q);
    assign match_d    = buf_valid_q && (daddr_line == buf_addr_q);

    // Next-state and buffer update. IDLE arbitration is a strict priority chain.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        buf_valid_d = buf_valid_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        case (state_q)
            StIdle: begin
                if (dread && match_d) begin
                    state_d = StFwdD;
                end else if (dread) begin
                    state_d = StDrd;
                    addr_d  = daddr_line;
                end else if (dwrite && (!buf_valid_q || match_d)) begin
                    // Empty buffer, or same line: capture (coalescing overwrites).
                    state_d     = StWack;
                    buf_valid_d = 1'b1;
                    buf_addr_d  = daddr_line;
                    buf_data_d  = wdata;
                end else if (dwrite) begin
                    // Different dirty line already parked: flush it, then retry the write.
                    state_d = StDrain;
                end else if (iread && match_i) begin
                    state_d = StFwdI;
                end else if (iread) begin
                    state_d = StIrd;
                    addr_d  = iaddr_line;
                end else if (buf_valid_q) begin
                    state_d = StDrain;
                end
            end
            StIrd, StDrd: begin
                if (mem_resp) state_d = StDone;
            end
            StDrain: begin
                if (mem_resp) begin
                    buf_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            StFwdI, StFwdD, StWack: state_d = StDone;
            // Dead cycle: a request still held during its response cycle is not re-granted.
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode the registered state; read data passes straight through from L2.
    always_comb begin
        iresp       = 1'b0;
        i_rdata     = '0;
        dresp       = 1'b0;
        d_rdata     = '0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        case (state_q)
            StIrd: begin
                mem_read    = 1'b1;
                mem_address = addr_q;
                if (mem_resp) begin
                    iresp   = 1'b1;
                    i_rdata = mem_rdata;
                end
            end
            StDrd: begin
                mem_read    = 1'b1;
                mem_address = addr_q;
                if (mem_resp) begin
                    dresp   = 1'b1;
                    d_rdata = mem_rdata;
                end
            end
            StDrain: begin
                mem_write   = 1'b1;
                mem_address = buf_addr_q;
                mem_wdata   = buf_data_q;
            end
            StFwdI: begin
                iresp   = 1'b1;
                i_rdata = buf_data_q;
            end
            StFwdD: begin
                dresp   = 1'b1;
                d_rdata = buf_data_q;
            end
            StWack: dresp = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
        end
    end

endmodule

// File: tb/tb_l2_wb_arbiter.sv
// Bench for l2_wb_arbiter: a per-cycle vector table for the directed scenarios, a hand
// sequence for reset during an L2 read, and a randomized phase checked against a
// line-level memory model (every read must return the latest acknowledged write).
module tb_l2_wb_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 256;
    localparam int unsigned OFF_W  = 5;

    localparam logic [LINE_W-1:0] Z  = '0;
    localparam logic [LINE_W-1:0] DA = {8{32'hAAAA_0001}};
    localparam logic [LINE_W-1:0] DB = {8{32'hBBBB_0002}};
    localparam logic [LINE_W-1:0] DC = {8{32'hCCCC_0003}};
    localparam logic [LINE_W-1:0] DE = {8{32'hEEEE_0005}};
    localparam logic [LINE_W-1:0] DF = {8{32'hFFFF_0006}};
    localparam logic [LINE_W-1:0] D1 = {8{32'h1111_1111}};
    localparam logic [LINE_W-1:0] D2 = {8{32'h2222_2222}};
    localparam logic [LINE_W-1:0] D3 = {8{32'h3333_3333}};
    localparam logic [LINE_W-1:0] D4 = {8{32'h4444_4444}};
    localparam logic [LINE_W-1:0] D5 = {8{32'h5555_5555}};
    localparam logic [LINE_W-1:0] DJ = {8{32'hDEAD_BEEF}};

    logic              clk = 1'b0;
    logic              rst_n;
    logic              iread, dread, dwrite, mem_resp;
    logic [ADDR_W-1:0] iaddress, daddress;
    logic [LINE_W-1:0] wdata, mem_rdata;
    logic              iresp, dresp, mem_read, mem_write;
    logic [LINE_W-1:0] i_rdata, d_rdata, mem_wdata;
    logic [ADDR_W-1:0] mem_address;

    int n_tests = 0;
    int n_fail  = 0;

    l2_wb_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .OFF_W(OFF_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .iread(iread), .iaddress(iaddress), .iresp(iresp), .i_rdata(i_rdata),
        .dread(dread), .dwrite(dwrite), .daddress(daddress), .wdata(wdata),
        .dresp(dresp), .d_rdata(d_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string name, input int idx, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %b, expected %b", name, idx, act, exp);
        end
    endtask

    task automatic check_addr(input string name, input int idx, input logic [ADDR_W-1:0] act,
                              input logic [ADDR_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input int idx, input logic [LINE_W-1:0] act,
                             input logic [LINE_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // ------------------------------------------------------------------ vector table
    typedef struct {
        logic              ir;
        logic [ADDR_W-1:0] ia;
        logic              dr;
        logic              dw;
        logic [ADDR_W-1:0] da;
        logic [LINE_W-1:0] wd;
        logic              mr;
        logic [LINE_W-1:0] md;
        logic              e_ir;
        logic [LINE_W-1:0] e_id;
        logic              e_dr;
        logic [LINE_W-1:0] e_dd;
        logic              e_mrd;
        logic              e_mwr;
        logic [ADDR_W-1:0] e_ma;
        logic [LINE_W-1:0] e_mwd;
    } vec_t;

    vec_t vecs[$];
    vec_t cur;

    task automatic vi(input int ir, input int unsigned ia, input int dr, input int dw,
                      input int unsigned da, input logic [LINE_W-1:0] wd, input int mr,
                      input logic [LINE_W-1:0] md);
        cur.ir = (ir != 0); cur.ia = ia; cur.dr = (dr != 0); cur.dw = (dw != 0);
        cur.da = da; cur.wd = wd; cur.mr = (mr != 0); cur.md = md;
    endtask

    task automatic ve(input int e_ir, input logic [LINE_W-1:0] e_id, input int e_dr,
                      input logic [LINE_W-1:0] e_dd, input int e_mrd, input int e_mwr,
                      input int unsigned e_ma, input logic [LINE_W-1:0] e_mwd);
        cur.e_ir = (e_ir != 0); cur.e_id = e_id; cur.e_dr = (e_dr != 0); cur.e_dd = e_dd;
        cur.e_mrd = (e_mrd != 0); cur.e_mwr = (e_mwr != 0); cur.e_ma = e_ma;
        cur.e_mwd = e_mwd;
        vecs.push_back(cur);
    endtask

    task automatic vz();
        ve(0, Z, 0, Z, 0, 0, 0, Z);
    endtask

    task automatic fill_table();
        // Read after reset release, then L2 read with pass-through data.
        vi(1, 'h123, 0, 0, 0, Z, 0, Z);    vz();                                // 0 idle
        vi(1, 'h123, 0, 0, 0, Z, 0, Z);    ve(0, Z, 0, Z, 1, 0, 'h120, Z);      // 1 IRD
        vi(1, 'h123, 0, 0, 0, Z, 1, D1);   ve(1, D1, 0, Z, 1, 0, 'h120, Z);     // 2 resp
        vi(0, 0, 0, 0, 0, Z, 0, Z);        vz();                                // 3 DONE
        // Simultaneous iread/dread: dcache wins, icache follows.
        vi(1, 'h100, 1, 0, 'h200, Z, 0, Z); vz();                               // 4
        vi(1, 'h100, 1, 0, 'h200, Z, 0, Z); ve(0, Z, 0, Z, 1, 0, 'h200, Z);     // 5 DRD
        vi(1, 'h100, 1, 0, 'h200, Z, 1, D2); ve(0, Z, 1, D2, 1, 0, 'h200, Z);   // 6
        vi(1, 'h100, 0, 0, 0, Z, 0, Z);    vz();                                // 7 DONE
        vi(1, 'h100, 0, 0, 0, Z, 0, Z);    vz();                                // 8 idle
        vi(1, 'h100, 0, 0, 0, Z, 1, D3);   ve(1, D3, 0, Z, 1, 0, 'h100, Z);     // 9 IRD
        vi(0, 0, 0, 0, 0, Z, 0, Z);        vz();                                // 10 DONE
        // Write-back into empty buffer, acked without L2, then idle drain.
        vi(0, 0, 0, 1, 'h404, DA, 0, Z);   vz();                                // 11
        vi(0, 0, 0, 1, 'h404, DA, 0, Z);   ve(0, Z, 1, Z, 0, 0, 0, Z);          // 12 WACK
        vi(0, 0, 0, 0, 0, Z, 0, Z);        vz();                                // 13 DONE
        vi(0, 0, 0, 0, 0, Z, 0, Z);        vz();                                // 14 idle
        vi(0, 0, 0, 0, 0, Z, 0, Z);        ve(0, Z, 0, Z, 0, 1, 'h400, DA);     // 15 DRAIN
        vi(0, 0, 0, 0, 0, Z, 1, Z);        ve(0, Z, 0, Z, 0, 1, 'h400, DA);     // 16
        // Refill buffer, then a dread in the same line is forwarded.
        vi(0, 0, 0, 1, 'h400, DA, 0, Z);   vz();                                // 17
        vi(0, 0, 0, 1, 'h400, DA, 0, Z);   ve(0, Z, 1, Z, 0, 0, 0, Z);          // 18 WACK
        vi(0, 0, 1, 0, 'h41C, Z, 0, Z);    vz();                                // 19 DONE
        vi(0, 0, 1, 0, 'h41C, Z, 0, Z);    vz();                                // 20 idle
        vi(0, 0, 1, 0, 'h41C, Z, 0, Z);    ve(0, Z, 1, DA, 0, 0, 0, Z);         // 21 FWD_D
        vi(0, 0, 0, 0, 0, Z, 0, Z);        vz();                                // 22 DONE
        // Write to another line forces the old line out first.
        vi(0, 0, 0, 1, 'h800, DB, 0, Z);   vz();                                // 23
        vi(0, 0, 0, 1, 'h800, DB, 0, Z);   ve(0, Z, 0, Z, 0, 1, 'h400, DA);     // 24 DRAIN
        vi(0, 0, 0, 1, 'h800, DB, 1, Z);   ve(0, Z, 0, Z, 0, 1, 'h400, DA);     // 25
        vi(0, 0, 0, 1, 'h800, DB, 0, Z);   vz();                                // 26 idle
        vi(0, 0, 0, 1, 'h800, DB, 0, Z);   ve(0, Z, 1, Z, 0, 0, 0, Z);          // 27 WACK
        // Same-line write coalesces; drain writes the newer data.
        vi(0, 0, 0, 1, 'h800, DC, 0, Z);   vz();                                // 28 DONE
        vi(0, 0, 0, 1, 'h800, DC, 0, Z);   vz();                                // 29 idle
        vi(0, 0, 0, 1, 'h800, DC, 0, Z);   ve(0, Z, 1, Z, 0, 0, 0, Z);          // 30 WACK
        vi(0, 0, 0, 0, 0, Z, 0, Z);        vz();                                // 31 DONE
        vi(0, 0, 0, 0, 0, Z, 0, Z);        vz();                                // 32 idle
        vi(0, 0, 0, 0, 0, Z, 1, Z);        ve(0, Z, 0, Z, 0, 1, 'h800, DC);     // 33 DRAIN
        // Buffer now empty: dread goes to L2; stray mem_resp in IDLE/DONE ignored.
        vi(0, 0, 1, 0, 'h800, Z, 1, DJ);   vz();                                // 34 idle
        vi(0, 0, 1, 0, 'h800, Z, 1, D4);   ve(0, Z, 1, D4, 1, 0, 'h800, Z);     // 35 DRD
        vi(0, 0, 0, 0, 0, Z, 1, DJ);       vz();                                // 36 DONE
        // icache forward from buffer.
        vi(0, 0, 0, 1, 'hC00, DE, 0, Z);   vz();                                // 37
        vi(0, 0, 0, 1, 'hC00, DE, 0, Z);   ve(0, Z, 1, Z, 0, 0, 0, Z);          // 38 WACK
        vi(1, 'hC10, 0, 0, 0, Z, 0, Z);    vz();                                // 39 DONE
        vi(1, 'hC10, 0, 0, 0, Z, 0, Z);    vz();                                // 40 idle
        vi(1, 'hC10, 0, 0, 0, Z, 0, Z);    ve(1, DE, 0, Z, 0, 0, 0, Z);         // 41 FWD_I
        vi(0, 0, 0, 0, 0, Z, 0, Z);        vz();                                // 42 DONE
        vi(0, 0, 0, 0, 0, Z, 0, Z);        vz();                                // 43 idle
        vi(0, 0, 0, 0, 0, Z, 0, Z);        ve(0, Z, 0, Z, 0, 1, 'hC00, DE);     // 44 DRAIN
        vi(0, 0, 0, 0, 0, Z, 1, Z);        ve(0, Z, 0, Z, 0, 1, 'hC00, DE);     // 45
        vi(0, 0, 0, 0, 0, Z, 0, Z);        vz();                                // 46 idle
    endtask

    // ------------------------------------------------------------------ line-level model
    logic [LINE_W-1:0] l2_mem [int unsigned];   // what the L2 actually holds
    logic [LINE_W-1:0] golden [int unsigned];   // latest acknowledged data per line

    logic              i_pend, d_pend, d_wr;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [LINE_W-1:0] d_data;
    int                i_age, d_age, l2_wait, l2_lat;

    function automatic logic [LINE_W-1:0] init_line(input int unsigned line);
        logic [31:0] h;
        h = line * 32'h9E37_79B1 + 32'h0BAD_F00D;
        return {8{h}};
    endfunction

    function automatic logic [LINE_W-1:0] l2_get(input int unsigned line);
        if (l2_mem.exists(line)) return l2_mem[line];
        return init_line(line);
    endfunction

    function automatic logic [LINE_W-1:0] golden_get(input int unsigned line);
        if (golden.exists(line)) return golden[line];
        return init_line(line);
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] r;
        for (int w = 0; w < int'(LINE_W / 32); w++) r[w*32 +: 32] = $urandom();
        return r;
    endfunction

    // Eight lines from 0x1000 so buffer hits and conflicts are frequent.
    function automatic logic [ADDR_W-1:0] rand_addr();
        return 32'h1000 + $urandom_range(7) * 32 + $urandom_range(31);
    endfunction

    task automatic check_invariants(input int idx);
        logic ok;
        ok = !(mem_read && mem_write)
             && (mem_address[OFF_W-1:0] == '0)
             && (mem_read || mem_write || mem_address == '0)
             && (mem_write || mem_wdata == '0)
             && (iresp || i_rdata == '0)
             && (dresp || d_rdata == '0);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL invariants [%0d]: rd=%b wr=%b addr=%h ir=%b dr=%b (required: %s)",
                     idx, mem_read, mem_write, mem_address, iresp, dresp,
                     "exclusive strobes, aligned addr, zero addr/data/rdata when inactive");
        end
    endtask

    task automatic rand_cycle(input int idx, input bit allow_new);
        int unsigned line;
        if (allow_new && !i_pend && $urandom_range(2) == 0) begin
            i_pend = 1'b1;
            i_addr = rand_addr();
            i_age  = 0;
        end
        if (allow_new && !d_pend && $urandom_range(2) == 0) begin
            d_pend = 1'b1;
            d_wr   = ($urandom_range(1) == 1);
            d_addr = rand_addr();
            d_data = rand_line();
            d_age  = 0;
        end
        iread    = i_pend;
        iaddress = i_addr;
        dread    = d_pend && !d_wr;
        dwrite   = d_pend && d_wr;
        daddress = d_addr;
        wdata    = d_data;
        mem_resp  = 1'b0;
        mem_rdata = rand_line();    // junk that must never reach a requester
        if (mem_read || mem_write) begin
            if (l2_wait >= l2_lat) begin
                line     = mem_address >> OFF_W;
                mem_resp = 1'b1;
                if (mem_read) mem_rdata = l2_get(line);
                else          l2_mem[line] = mem_wdata;
                l2_wait = 0;
                l2_lat  = $urandom_range(3);
            end else begin
                l2_wait++;
            end
        end
        #1;
        check_invariants(idx);
        if (iresp) begin
            if (!i_pend) begin
                check_bit("i_spurious_resp", idx, iresp, 1'b0);
            end else begin
                check_vec("i_read_data", idx, i_rdata, golden_get(i_addr >> OFF_W));
                i_pend = 1'b0;
            end
        end
        if (dresp) begin
            if (!d_pend) begin
                check_bit("d_spurious_resp", idx, dresp, 1'b0);
            end else begin
                if (d_wr) golden[d_addr >> OFF_W] = d_data;
                else check_vec("d_read_data", idx, d_rdata, golden_get(d_addr >> OFF_W));
                d_pend = 1'b0;
            end
        end
        if (i_pend && ++i_age > 200) begin
            n_tests++; n_fail++;
            $display("FAIL i_timeout [%0d]: no iresp after 200 cycles, expected one", idx);
            i_pend = 1'b0;
        end
        if (d_pend && ++d_age > 200) begin
            n_tests++; n_fail++;
            $display("FAIL d_timeout [%0d]: no dresp after 200 cycles, expected one", idx);
            d_pend = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------ main sequence
    initial begin
        logic quiet;
        int   guard;
        rst_n = 1'b0;
        iread = 1'b1; iaddress = 'h123;
        dread = 1'b0; dwrite = 1'b0; daddress = '0; wdata = '0;
        mem_resp = 1'b0; mem_rdata = '0;

        // Reset held with a pending iread: everything quiet.
        step();
        step();
        check_bit("rst_iresp", 0, iresp, 1'b0);
        check_bit("rst_dresp", 0, dresp, 1'b0);
        check_bit("rst_mem_read", 0, mem_read, 1'b0);
        check_bit("rst_mem_write", 0, mem_write, 1'b0);
        check_addr("rst_mem_address", 0, mem_address, '0);
        check_vec("rst_mem_wdata", 0, mem_wdata, Z);
        check_vec("rst_i_rdata", 0, i_rdata, Z);
        check_vec("rst_d_rdata", 0, d_rdata, Z);
        rst_n = 1'b1;

        fill_table();
        for (int k = 0; k < vecs.size(); k++) begin
            iread = vecs[k].ir; iaddress = vecs[k].ia;
            dread = vecs[k].dr; dwrite = vecs[k].dw; daddress = vecs[k].da;
            wdata = vecs[k].wd; mem_resp = vecs[k].mr; mem_rdata = vecs[k].md;
            #1;
            check_bit("iresp", k, iresp, vecs[k].e_ir);
            check_vec("i_rdata", k, i_rdata, vecs[k].e_id);
            check_bit("dresp", k, dresp, vecs[k].e_dr);
            check_vec("d_rdata", k, d_rdata, vecs[k].e_dd);
            check_bit("mem_read", k, mem_read, vecs[k].e_mrd);
            check_bit("mem_write", k, mem_write, vecs[k].e_mwr);
            check_addr("mem_address", k, mem_address, vecs[k].e_ma);
            check_vec("mem_wdata", k, mem_wdata, vecs[k].e_mwd);
            step();
        end

        // Reset in the middle of an L2 read also throws away the buffered line.
        iread = 1'b0; dread = 1'b0; mem_resp = 1'b0; mem_rdata = '0;
        dwrite = 1'b1; daddress = 'h600; wdata = DF;
        step();                                         // WACK
        check_bit("hs_wack_dresp", 0, dresp, 1'b1);
        dwrite = 1'b0;
        step();                                         // DONE
        iread = 1'b1; iaddress = 'h300;
        step();                                         // IDLE: read beats drain
        step();                                         // IRD
        check_bit("hs_ird_mem_read", 0, mem_read, 1'b1);
        check_addr("hs_ird_addr", 0, mem_address, 'h300);
        step();                                         // still waiting on L2
        rst_n = 1'b0;
        #1;
        check_bit("hs_rst_iresp", 0, iresp, 1'b0);
        check_bit("hs_rst_mem_read", 0, mem_read, 1'b0);
        check_addr("hs_rst_addr", 0, mem_address, '0);
        step();
        rst_n = 1'b1; iread = 1'b0;
        quiet = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (mem_write || mem_read || iresp || dresp) quiet = 1'b0;
            step();
        end
        check_bit("hs_no_drain_after_rst", 0, quiet, 1'b1);
        dread = 1'b1; daddress = 'h608;
        step();                                         // IDLE sampled -> DRD, not forward
        check_bit("hs_drd_mem_read", 0, mem_read, 1'b1);
        check_addr("hs_drd_addr", 0, mem_address, 'h600);
        check_bit("hs_drd_no_fwd", 0, dresp, 1'b0);
        mem_resp = 1'b1; mem_rdata = D5;
        #1;
        check_bit("hs_drd_dresp", 0, dresp, 1'b1);
        check_vec("hs_drd_data", 0, d_rdata, D5);
        dread = 1'b0; mem_resp = 1'b0; mem_rdata = '0;
        step();
        step();

        // Randomized traffic against the line-level model.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        l2_mem.delete(); golden.delete();
        i_pend = 1'b0; d_pend = 1'b0; d_wr = 1'b0;
        i_addr = '0; d_addr = '0; d_data = '0;
        i_age = 0; d_age = 0; l2_wait = 0; l2_lat = 1;
        for (int c = 0; c < 3000; c++) rand_cycle(c, 1'b1);
        guard = 0;
        while ((i_pend || d_pend) && guard < 500) begin
            rand_cycle(3000 + guard, 1'b0);
            guard++;
        end
        for (int c = 0; c < 30; c++) rand_cycle(4000 + c, 1'b0);
        // Once idle, the buffer has drained: L2 must hold every acknowledged write.
        for (int unsigned l = 128; l < 136; l++) begin
            check_vec("l2_final", int'(l), l2_get(l), golden_get(l));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected $finish");
        $fatal(1);
    end

endmodule
